// File: rtl/req_initiator_pkg.sv
// Shared definitions for both ends of the single-bit req/ack handshake.
//
// Contents:
//   state_t          - initiator state encoding (IDLE=0 .. ERROR=4, 3 bits)
//   *_DEFAULT        - default timeout and inter-transaction gap
//   ACK_PULSE_CYCLES - ack is a single-cycle pulse, so one sample per
//                      transaction is enough to see it
//   TIMEOUT_W/GAP_W  - widths of the timeout and gap counters
//   timer_last()     - terminal count for a counter that runs from 0 for
//                      'limit' cycles
package req_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT  = 15;
    localparam int unsigned GAP_DEFAULT      = 0;
    localparam int unsigned ACK_PULSE_CYCLES = 1;

    localparam int unsigned TIMEOUT_W = 8;
    localparam int unsigned GAP_W     = 4;

    // A counter started at 0 spends 'limit' cycles reaching limit-1.
    // A limit of 0 maps to 0; callers that allow 0 never consult it.
    function automatic int unsigned timer_last(input int unsigned limit);
        return (limit == 0) ? 0 : limit - 1;
    endfunction

endpackage

// File: rtl/req_timer.sv
// Loadable up-counter with a terminal flag.
//
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset (count -> 0)
//   load_i         - load load_val_i on the next edge (has priority)
//   load_val_i     - value to load
//   inc_i          - increment by one on the next edge
//   last_i         - terminal count to compare against
//   last_o         - high while the current count equals last_i
module req_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == last_i);

endmodule

// File: rtl/req_initiator.sv
// Requester end of the req/ack handshake.
//
// Handshake: req is a one-cycle registered pulse that starts a transaction.
// The responder answers with a one-cycle ack pulse no earlier than the cycle
// after req. An ack in the WAIT state completes the transaction; an ack in the
// REQ cycle is a protocol error; an ack anywhere else is reported as stray.
//
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   go             - work pending, sampled only in IDLE
//   ack            - completion pulse from the responder
//   clr_err        - clears sticky err/stray_ack (err only from ERROR)
//   req            - request pulse to the responder
//   busy           - high in REQ, WAIT and HOLD
//   err            - sticky: ack timeout or ack during REQ
//   stray_ack      - sticky: ack seen in IDLE, HOLD or ERROR
//   txn_count      - completed transactions, wraps silently
//   dbg_state      - current state, for observation only
module req_initiator
    import req_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned GAP     = GAP_DEFAULT,
    parameter int unsigned CW      = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          go,
    input  logic          ack,
    input  logic          clr_err,
    output logic          req,
    output logic          busy,
    output logic          err,
    output logic          stray_ack,
    output logic [CW-1:0] txn_count,
    output state_t        dbg_state
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(timer_last(TIMEOUT));
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(timer_last(GAP));
    localparam bit                   HAS_GAP  = (GAP != 0);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          stray_q, stray_d;
    logic [CW-1:0] txn_q, txn_d;

    logic to_load, to_inc, to_last;
    logic gap_load, gap_inc, gap_last;

    // Timeout counter: cleared in REQ, counts WAIT cycles without ack.
    // Its terminal flag fires in the TIMEOUT-th WAIT cycle.
    assign to_load = (state_q == ST_REQ);
    assign to_inc  = (state_q == ST_WAIT) && !ack;

    req_timer #(.W(TIMEOUT_W)) u_timeout (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (to_load),
        .load_val_i ('0),
        .inc_i      (to_inc),
        .last_i     (TO_LAST),
        .last_o     (to_last)
    );

    // Gap counter: cleared while waiting, counts HOLD cycles.
    assign gap_load = (state_q == ST_WAIT);
    assign gap_inc  = (state_q == ST_HOLD);

    req_timer #(.W(GAP_W)) u_gap (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (gap_load),
        .load_val_i ('0),
        .inc_i      (gap_inc),
        .last_i     (GAP_LAST),
        .last_o     (gap_last)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        stray_d = stray_q;
        txn_d   = txn_q;

        case (state_q)
            ST_IDLE: begin
                if (ack) stray_d = 1'b1;
                if (go)  state_d = ST_REQ;
            end
            ST_REQ: begin
                // The responder cannot legally answer in the request cycle.
                if (ack) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // ack is checked first so an ack in the final cycle still counts.
                if (ack) begin
                    txn_d   = txn_q + CW'(1);
                    state_d = HAS_GAP ? ST_HOLD : ST_IDLE;
                end else if (to_last) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ack)      stray_d = 1'b1;
                if (gap_last) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (ack) stray_d = 1'b1;
                if (clr_err) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear in the same cycle as a stray ack wins.
        if (clr_err) stray_d = 1'b0;

        // req and busy are registered decodes of the next state.
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            stray_q <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            stray_q <= stray_d;
            txn_q   <= txn_d;
        end
    end

    assign req       = req_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign stray_ack = stray_q;
    assign txn_count = txn_q;
    assign dbg_state = state_q;

endmodule
